// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART blocks (fifo_uart_tx today, a
// future uart_rx tomorrow).
//   uart_state_t         : frame state machine encoding
//   CLKS_PER_BIT_115200  : bit period in CLOCK_50 cycles for ~115200 baud
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // 50 MHz / 115200 = 434.03
    localparam int CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period. Written to be shared with a future receiver.
//   clk    in  : system clock
//   reset  in  : synchronous, active-high reset
//   clear  in  : hold the counter at 0 (start of a new frame)
//   tick   out : high on the last cycle of each bit period
// -----------------------------------------------------------------------------
module baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Wrap by explicit compare so non-power-of-two periods work.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains a show-ahead FIFO and sends each word as an 8N1 frame, LSB first.
//   clk      in          : system clock
//   reset    in          : synchronous, active-high reset
//   empty    in          : FIFO empty flag
//   data_in  in  [width] : FIFO head word (valid while empty = 0)
//   read     out         : one-cycle pop strobe (combinational)
//   tx       out         : serial line, idle high (registered)
//   busy     out         : frame in flight (registered)
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int width        = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             empty,
    input  logic [width-1:0] data_in,
    output logic             read,
    output logic             tx,
    output logic             busy
);

    localparam int            BW       = (width > 1) ? $clog2(width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

    uart_state_t      state;
    logic [width-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             baud_clr;

    // Pop only from IDLE; reset masks it so a word is never lost to reset.
    assign read = (state == IDLE) && !empty && !reset;

    // Baud timer is parked at 0 while idle, so START always gets a full period.
    assign baud_clr = (state == IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clr),
        .tick  (tick)
    );

    // tx is registered, so each transition loads the level of the *next* bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read) begin
                        shift_reg <= data_in;
                        bit_cnt   <= '0;
                        state     <= START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        tx    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    // tx already high; one IDLE cycle follows before the next pop.
                    if (tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with CLKS_PER_BIT = 4, width = 8. A queue
// models the show-ahead FIFO; bytes loaded into it are also pushed onto an
// expected queue and popped by a mid-bit sampling receiver model.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         empty;
    logic [W-1:0] data_in;
    logic         read;
    logic         tx;
    logic         busy;

    fifo_uart_tx #(
        .width        (W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .empty   (empty),
        .data_in (data_in),
        .read    (read),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           rd_q[$];
    logic         hold_empty = 1'b0;

    int   cyc_n = 0;
    logic tx_hist   [8192];
    logic busy_hist [8192];

    // receiver model state
    logic         rx_act = 1'b0;
    int           rx_cnt = 0;
    logic [W-1:0] rx_byte;
    int           frames = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        empty   = hold_empty || (fifo_q.size() == 0);
        data_in = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic load(input logic [W-1:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        drive_fifo();
    endtask

    task automatic rx_step(input logic ts);
        int k;
        if (!rx_act) begin
            if (ts === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_act && (rx_cnt % CPB == CPB / 2)) begin
            k = rx_cnt / CPB;
            if (k == 0) begin
                chk("start_bit", ts, 1'b0);
            end else if (k <= W) begin
                rx_byte[k-1] = ts;
            end else begin
                chk("stop_bit", ts, 1'b1);
                chk("exp_avail", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("rx_byte", rx_byte, exp_q.pop_front());
                frames++;
                rx_act = 1'b0;
            end
        end
    endtask

    // One clock: sample at negedge, FIFO pops and input updates after posedge.
    task automatic cyc();
        logic rs, ts, bs;
        @(negedge clk);
        rs = read; ts = tx; bs = busy;
        tx_hist[cyc_n]   = ts;
        busy_hist[cyc_n] = bs;
        if (rs === 1'b1) rd_q.push_back(cyc_n);
        chk("read_in_frame", rs & bs, 1'b0);
        rx_step(ts);
        @(posedge clk);
        #1;
        if (rs === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        cyc_n++;
        drive_fifo();
    endtask

    initial begin
        int r;
        int f0;
        int n;
        logic [W-1:0] a5;
        logic         bitv;

        reset = 1'b1;
        drive_fifo();
        @(posedge clk);
        #1;

        // reset with empty FIFO, then stay idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", tx, 1'b1);
            chk("rst_read", read, 1'b0);
            chk("rst_busy", busy, 1'b0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx", tx, 1'b1);
            chk("idle_read", read, 1'b0);
            chk("idle_busy", busy, 1'b0);
            @(posedge clk);
            #1;
        end

        // single frame 8'hA5, exact line pattern
        rd_q.delete();
        f0 = frames;
        a5 = 8'hA5;
        load(a5);
        repeat (50) cyc();
        chk("a5_reads", rd_q.size(), 1);
        if (rd_q.size() >= 1) begin
            r = rd_q[0];
            chk("a5_idle_tx", tx_hist[r], 1'b1);
            for (int g = 0; g < W + 2; g++) begin
                if (g == 0)      bitv = 1'b0;
                else if (g <= W) bitv = a5[g-1];
                else             bitv = 1'b1;
                for (int j = 0; j < CPB; j++)
                    chk("a5_tx", tx_hist[r + 1 + g*CPB + j], bitv);
            end
            chk("a5_busy_first", busy_hist[r + 1], 1'b1);
            chk("a5_busy_last", busy_hist[r + (W+2)*CPB], 1'b1);
            chk("a5_busy_done", busy_hist[r + (W+2)*CPB + 1], 1'b0);
        end
        chk("a5_frames", frames - f0, 1);

        // back-to-back 8'h01, 8'hFF
        rd_q.delete();
        f0 = frames;
        load(8'h01);
        load(8'hFF);
        repeat (95) cyc();
        chk("b2b_reads", rd_q.size(), 2);
        if (rd_q.size() == 2) chk("b2b_gap", rd_q[1] - rd_q[0], 1 + (W+2)*CPB);
        chk("b2b_frames", frames - f0, 2);

        // empty toggling mid-frame
        rd_q.delete();
        f0 = frames;
        load(8'h3C);
        cyc();
        hold_empty = 1'b1;
        load(8'h96);
        for (int i = 0; i < 30; i++) begin
            hold_empty = (i % 2 == 1);
            drive_fifo();
            cyc();
        end
        hold_empty = 1'b0;
        drive_fifo();
        repeat (60) cyc();
        chk("tog_reads", rd_q.size(), 2);
        if (rd_q.size() == 2) chk("tog_gap", rd_q[1] - rd_q[0], 1 + (W+2)*CPB);
        chk("tog_frames", frames - f0, 2);

        // reset during DATA bit 3
        rd_q.delete();
        f0 = frames;
        load(8'hC3);
        load(8'h7E);
        cyc();
        repeat (17) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rx_act = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_read", read, 1'b1);
        @(posedge clk);
        #1;
        // the pop above belongs to the next frame
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        rd_q.push_back(cyc_n);
        cyc_n++;
        drive_fifo();
        rx_act = 1'b0;
        repeat (50) cyc();
        chk("abort_reads", rd_q.size(), 2);
        chk("abort_frames", frames - f0, 1);

        // 16 random bytes
        f0 = frames;
        for (int i = 0; i < 16; i++) load(W'($urandom_range(0, 255)));
        n = 0;
        while (exp_q.size() != 0 && n < 16 * 45 + 100) begin
            cyc();
            n++;
        end
        chk("rand_drain", exp_q.size(), 0);
        repeat (5) cyc();
        chk("rand_frames", frames - f0, 16);
        chk("rand_fifo_empty", empty, 1'b1);
        chk("rand_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
